// File: rtl/ball_monitor_if.sv
// Signal bundle between the ball physics source and the ball monitor.
// The master side drives position and clear requests; the slave side reports motion.
interface ball_monitor_if;
  logic [16:0] position;
  logic        clr_cnt;
  logic [1:0]  dir;
  logic [7:0]  bounce_cnt;
  logic [16:0] apex;
  logic        hit_top;
  logic        beep;
  logic        stopped;

  modport master (
    output position, clr_cnt,
    input  dir, bounce_cnt, apex, hit_top, beep, stopped
  );

  modport slave (
    input  position, clr_cnt,
    output dir, bounce_cnt, apex, hit_top, beep, stopped
  );
endinterface

// File: rtl/ball_monitor.sv
// Samples the ball height stream, classifies motion (fall/rise/rest), counts floor
// bounces, tracks the apex of each rise and times a beep on every impact.
module ball_monitor #(
  parameter int unsigned SAMPLE_DIV   = 48_000,
  parameter int unsigned BOTTOM       = 310,
  parameter int unsigned TOP          = 20,
  parameter int unsigned REST_SAMPLES = 8,
  parameter int unsigned BEEP_LEN     = 1_200_000
) (
  input logic           clk,
  input logic           rst,
  ball_monitor_if.slave bus
);

  localparam int unsigned DivW  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned BeepW = $clog2(BEEP_LEN + 1);
  localparam int unsigned RestW = $clog2(REST_SAMPLES + 1);

  localparam logic [16:0]      Bottom   = 17'(BOTTOM);
  localparam logic [16:0]      Top      = 17'(TOP);
  localparam logic [DivW-1:0]  DivLast  = DivW'(SAMPLE_DIV - 1);
  localparam logic [BeepW-1:0] BeepLoad = BeepW'(BEEP_LEN);
  localparam logic [RestW-1:0] RestMax  = RestW'(REST_SAMPLES);

  typedef enum logic [1:0] {
    StFall = 2'b00,
    StRest = 2'b01,
    StRise = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [16:0]       sync1_q, sync2_q, raw_q, cur_q;
  logic [DivW-1:0]   div_q, div_d;
  logic [RestW-1:0]  rest_q, rest_d, rest_next;
  logic [7:0]        cnt_q, cnt_d;
  logic [16:0]       tracker_q, tracker_d;
  logic [16:0]       apex_q, apex_d;
  logic              hit_q, hit_d;
  logic [BeepW-1:0]  beep_q, beep_d;

  logic              tick, accept, at_floor, rest_done, delta_neg, delta_pos;
  logic              impact, floor_hit;
  logic signed [17:0] delta;

  assign tick   = (div_q == DivLast);
  // Two equal consecutive tick samples guard against a multi-bit update caught mid-flight.
  assign accept = tick && (sync2_q == raw_q);

  // At the evaluation edge cur_q still holds the previous accepted sample.
  assign delta     = $signed({1'b0, sync2_q}) - $signed({1'b0, cur_q});
  assign delta_neg = delta[17];
  assign delta_pos = !delta[17] && (delta != 18'sd0);

  assign at_floor  = (sync2_q == Bottom);
  assign rest_next = !at_floor ? '0 : (rest_q == RestMax) ? rest_q : rest_q + RestW'(1);
  assign rest_done = at_floor && (rest_next == RestMax);

  always_comb begin
    state_d   = state_q;
    rest_d    = rest_q;
    tracker_d = tracker_q;
    apex_d    = apex_q;
    hit_d     = 1'b0;
    impact    = 1'b0;
    floor_hit = 1'b0;
    div_d     = tick ? '0 : div_q + DivW'(1);
    beep_d    = (beep_q != '0) ? beep_q - BeepW'(1) : '0;
    cnt_d     = bus.clr_cnt ? 8'd0 : cnt_q;

    if (accept) begin
      rest_d = rest_next;
      case (state_q)
        StRest: begin
          if (sync2_q < Bottom) state_d = StFall;
        end
        StFall: begin
          if (delta_neg && ((cur_q >= Bottom) || (sync2_q >= Bottom))) begin
            state_d   = StRise;
            floor_hit = 1'b1;
            impact    = 1'b1;
            tracker_d = sync2_q;
          end else if (rest_done) begin
            state_d = StRest;
          end
        end
        StRise: begin
          if (rest_done) begin
            state_d = StRest;
          end else if (sync2_q <= Top) begin
            state_d = StFall;
            hit_d   = 1'b1;
            impact  = 1'b1;
            apex_d  = sync2_q;
          end else if (delta_pos) begin
            state_d = StFall;
            apex_d  = tracker_q;
          end else if (sync2_q < tracker_q) begin
            tracker_d = sync2_q;
          end
        end
        default: state_d = StRest;
      endcase
    end

    if (impact) beep_d = BeepLoad;
    // The clear has already been folded into cnt_d, so a coinciding impact lands on 1.
    if (floor_hit && (cnt_d != 8'hFF)) cnt_d = cnt_d + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      raw_q     <= '0;
      cur_q     <= Bottom;
      div_q     <= '0;
      state_q   <= StRest;
      rest_q    <= '0;
      cnt_q     <= '0;
      tracker_q <= Bottom;
      apex_q    <= Bottom;
      hit_q     <= 1'b0;
      beep_q    <= '0;
    end else begin
      sync1_q   <= bus.position;
      sync2_q   <= sync1_q;
      if (tick) raw_q <= sync2_q;
      if (accept) cur_q <= sync2_q;
      div_q     <= div_d;
      state_q   <= state_d;
      rest_q    <= rest_d;
      cnt_q     <= cnt_d;
      tracker_q <= tracker_d;
      apex_q    <= apex_d;
      hit_q     <= hit_d;
      beep_q    <= beep_d;
    end
  end

  assign bus.dir        = state_q;
  assign bus.stopped    = (state_q == StRest);
  assign bus.bounce_cnt = cnt_q;
  assign bus.apex       = apex_q;
  assign bus.hit_top    = hit_q;
  assign bus.beep       = (beep_q != '0);

endmodule

// File: tb/tb_ball_monitor.sv
// Directed bench for ball_monitor: a vector table for the motion sequences plus
// hand-written sequences for saturation, clear, glitch rejection and reset.
module tb_ball_monitor;
  localparam int unsigned SD  = 4;
  localparam int unsigned BL  = 10;
  localparam int unsigned RS  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  ball_monitor_if bus ();

  ball_monitor #(
    .SAMPLE_DIV  (SD),
    .BOTTOM      (310),
    .TOP         (20),
    .REST_SAMPLES(RS),
    .BEEP_LEN    (BL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] pos;
    int          ticks;
    logic [1:0]  dir;
    logic [7:0]  cnt;
    logic [16:0] apex;
    logic        stopped;
    logic        beep;
    logic        hit;
    logic        len;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [16:0] pos, input int ticks, input logic [1:0] dir,
                              input logic [7:0] cnt, input logic [16:0] apex,
                              input logic stopped, input logic beep, input logic hit,
                              input logic len);
    vec_t v;
    v.pos = pos; v.ticks = ticks; v.dir = dir; v.cnt = cnt; v.apex = apex;
    v.stopped = stopped; v.beep = beep; v.hit = hit; v.len = len;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Ends 1 time unit after a tick edge so every call stays aligned to the sample grid.
  task automatic settle(input logic [16:0] pos, input int ticks);
    bus.position = pos;
    repeat (ticks * SD) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [1:0] dir, input logic [7:0] cnt,
                           input logic [16:0] apex, input logic stopped, input logic beep,
                           input logic hit);
    check({tag, " dir"}, 32'(bus.dir), 32'(dir));
    check({tag, " cnt"}, 32'(bus.bounce_cnt), 32'(cnt));
    check({tag, " apex"}, 32'(bus.apex), 32'(apex));
    check({tag, " stopped"}, 32'(bus.stopped), 32'(stopped));
    check({tag, " beep"}, 32'(bus.beep), 32'(beep));
    check({tag, " hit_top"}, 32'(bus.hit_top), 32'(hit));
  endtask

  initial begin
    int beeps;
    int hits;
    int lows;
    bus.position = 17'd310;
    bus.clr_cnt  = 1'b0;

    // Reset held for two edges, then 310 held: nothing may move.
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 2'b01, 8'd0, 17'd310, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    beeps = 0;
    lows  = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (bus.beep) beeps++;
      if (!bus.stopped) lows++;
    end
    check("idle beep cycles", 32'(beeps), 32'd0);
    check("idle stopped low", 32'(lows), 32'd0);

    //               pos  tk dir    cnt apex st bp hit len
    vecs.push_back(mk(100, 2, 2'b00, 0, 310, 0, 0, 0, 0));
    vecs.push_back(mk(130, 2, 2'b00, 0, 310, 0, 0, 0, 0));
    vecs.push_back(mk(160, 2, 2'b00, 0, 310, 0, 0, 0, 0));
    vecs.push_back(mk(190, 2, 2'b00, 0, 310, 0, 0, 0, 0));
    vecs.push_back(mk(220, 2, 2'b00, 0, 310, 0, 0, 0, 0));
    vecs.push_back(mk(250, 2, 2'b00, 0, 310, 0, 0, 0, 0));
    vecs.push_back(mk(280, 2, 2'b00, 0, 310, 0, 0, 0, 0));
    vecs.push_back(mk(310, 2, 2'b00, 0, 310, 0, 0, 0, 0));
    vecs.push_back(mk(280, 2, 2'b11, 1, 310, 0, 1, 0, 1));
    vecs.push_back(mk(240, 2, 2'b11, 1, 310, 0, 0, 0, 0));
    vecs.push_back(mk(200, 2, 2'b11, 1, 310, 0, 0, 0, 0));
    vecs.push_back(mk(250, 2, 2'b00, 1, 200, 0, 0, 0, 0));
    vecs.push_back(mk(300, 2, 2'b00, 1, 200, 0, 0, 0, 0));
    vecs.push_back(mk(310, 2, 2'b00, 1, 200, 0, 0, 0, 0));
    vecs.push_back(mk(250, 2, 2'b11, 2, 200, 0, 1, 0, 0));
    vecs.push_back(mk(150, 2, 2'b11, 2, 200, 0, 1, 0, 0));
    vecs.push_back(mk(60,  2, 2'b11, 2, 200, 0, 0, 0, 0));
    vecs.push_back(mk(20,  2, 2'b00, 2, 20,  0, 1, 1, 1));
    vecs.push_back(mk(100, 2, 2'b00, 2, 20,  0, 0, 0, 0));
    vecs.push_back(mk(310, 2, 2'b00, 2, 20,  0, 0, 0, 0));
    vecs.push_back(mk(250, 2, 2'b11, 3, 20,  0, 1, 0, 0));
    vecs.push_back(mk(310, 2, 2'b00, 3, 250, 0, 1, 0, 0));
    vecs.push_back(mk(310, 1, 2'b00, 3, 250, 0, 0, 0, 0));
    vecs.push_back(mk(310, 1, 2'b01, 3, 250, 1, 0, 0, 0));
    vecs.push_back(mk(309, 2, 2'b00, 3, 250, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      settle(vecs[i].pos, vecs[i].ticks);
      check_all($sformatf("row%0d", i), vecs[i].dir, vecs[i].cnt, vecs[i].apex,
                vecs[i].stopped, vecs[i].beep, vecs[i].hit);
      if (vecs[i].len) begin
        beeps = 0;
        hits  = 0;
        for (int k = 0; k < 12; k++) begin
          if (bus.beep) beeps++;
          if (bus.hit_top) hits++;
          @(posedge clk);
          #1;
        end
        check($sformatf("row%0d beep length", i), 32'(beeps), 32'(BL));
        check($sformatf("row%0d hit_top cycles", i), 32'(hits), 32'(vecs[i].hit));
      end
    end

    // 260 floor bounces starting from a count of 3.
    for (int i = 0; i < 260; i++) begin
      settle(17'd310, 2);
      settle(17'd280, 2);
      if (i == 250) check("sat below", 32'(bus.bounce_cnt), 32'd254);
      if (i == 251) check("sat reach", 32'(bus.bounce_cnt), 32'd255);
    end
    check("sat hold", 32'(bus.bounce_cnt), 32'd255);
    check("sat dir", 32'(bus.dir), 32'b11);

    // Clear coinciding with the impact edge.
    settle(17'd310, 2);
    bus.position = 17'd280;
    repeat (7) @(posedge clk);
    #1;
    bus.clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_cnt = 1'b0;
    check("clr+impact cnt", 32'(bus.bounce_cnt), 32'd1);
    check("clr+impact dir", 32'(bus.dir), 32'b11);
    check("clr+impact beep", 32'(bus.beep), 32'd1);
    bus.clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_cnt = 1'b0;
    check("clr alone", 32'(bus.bounce_cnt), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Single-tick glitch to all-ones must be rejected.
    settle(17'd250, 2);
    check("pre-glitch dir", 32'(bus.dir), 32'b11);
    check("pre-glitch apex", 32'(bus.apex), 32'd280);
    bus.position = 17'h1FFFF;
    repeat (SD) @(posedge clk);
    #1;
    bus.position = 17'd250;
    check("glitch mid dir", 32'(bus.dir), 32'b11);
    repeat (2 * SD) @(posedge clk);
    #1;
    check("glitch dir", 32'(bus.dir), 32'b11);
    check("glitch apex", 32'(bus.apex), 32'd280);
    settle(17'd300, 2);
    check("post-glitch dir", 32'(bus.dir), 32'b00);
    check("post-glitch apex", 32'(bus.apex), 32'd250);

    // Reset in the middle of a beep.
    settle(17'd310, 2);
    settle(17'd280, 2);
    check("pre-rst cnt", 32'(bus.bounce_cnt), 32'd1);
    check("pre-rst beep", 32'(bus.beep), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all("mid-rst", 2'b01, 8'd0, 17'd310, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
